// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit: lane steering, strobes, extension; LSU_MISALIGNED_EN enables two-beat split
module lsu_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_store,
  input  logic [2:0]                           req_size,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [XLEN-1:0]                      req_wdata,
  input  logic [4:0]                           req_rd,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-$clog2(XLEN/8)-1:0] mem_addr,
  output logic [XLEN/8-1:0]                    mem_wstrb,
  output logic [XLEN-1:0]                      mem_wdata,
  input  logic                                 mem_gnt,
  input  logic                                 mem_rvalid,
  input  logic [XLEN-1:0]                      mem_rdata,
  output logic                                 rsp_valid,
  output logic [XLEN-1:0]                      rsp_data,
  output logic [4:0]                           rsp_rd,
  output logic                                 rsp_err
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int WA = ADDR_WIDTH - LB;

  // data_size_e encoding (funct3-style)
  localparam logic [2:0] SZ_BYTE_S = 3'd0;
  localparam logic [2:0] SZ_HALF_S = 3'd1;
  localparam logic [2:0] SZ_WORD   = 3'd2;
  localparam logic [2:0] SZ_BYTE_U = 3'd4;
  localparam logic [2:0] SZ_HALF_U = 3'd5;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;
  state_e state_q, state_d;

  logic [LB-1:0]   off;
  logic [LB+1:0]   nbytes;
  logic [NB-1:0]   mask;
  logic            size_ok, misaligned, req_err;
  logic [NB-1:0]   strb0;
  logic [XLEN-1:0] data0;
`ifdef LSU_MISALIGNED_EN
  logic [2*NB-1:0]   strb_wide;
  logic [2*XLEN-1:0] data_wide, pair;
  logic [NB-1:0]     strb1, strb1_q;
  logic [XLEN-1:0]   data1, wdata1_q, rdata0_q;
  logic              split_q;
`endif
  logic            store_q, we_q, err_q;
  logic [2:0]      size_q;
  logic [4:0]      rd_q;
  logic [LB-1:0]   off_q;
  logic [WA-1:0]   addr_q;
  logic [NB-1:0]   strb_q;
  logic [XLEN-1:0] wdata_q, rsp_data_q, raw, load_val;

  // Decode size, detect word-boundary crossing and steer store lanes for both beats.
  always_comb begin
    off     = req_addr[LB-1:0];
    size_ok = 1'b1;
    nbytes  = '0;
    mask    = '0;
    case (req_size)
      SZ_BYTE_S, SZ_BYTE_U: begin nbytes = (LB+2)'(1); mask = NB'(1);  end
      SZ_HALF_S, SZ_HALF_U: begin nbytes = (LB+2)'(2); mask = NB'(3);  end
      SZ_WORD:              begin nbytes = (LB+2)'(4); mask = NB'(15); end
      default:              size_ok = 1'b0;
    endcase
    misaligned = ((LB+2)'(off) + nbytes) > (LB+2)'(NB);
`ifdef LSU_MISALIGNED_EN
    strb_wide = {{NB{1'b0}}, mask} << off;
    data_wide = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
    strb0     = strb_wide[NB-1:0];
    strb1     = strb_wide[2*NB-1:NB];
    data0     = data_wide[XLEN-1:0];
    data1     = data_wide[2*XLEN-1:XLEN];
    req_err   = !size_ok;
`else
    strb0     = mask << off;
    data0     = req_wdata << {off, 3'b000};
    req_err   = !size_ok || misaligned;
`endif
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: stores skip the wait state, split accesses take a second beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = req_err ? RESP : REQ0;
`ifdef LSU_MISALIGNED_EN
      REQ0:  if (mem_gnt)    state_d = store_q ? (split_q ? REQ1 : RESP) : WAIT0;
      WAIT0: if (mem_rvalid) state_d = split_q ? REQ1 : RESP;
      REQ1:  if (mem_gnt)    state_d = store_q ? RESP : WAIT1;
      WAIT1: if (mem_rvalid) state_d = RESP;
`else
      REQ0:  if (mem_gnt)    state_d = store_q ? RESP : WAIT0;
      WAIT0: if (mem_rvalid) state_d = RESP;
`endif
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request on accept, advance to beat 1, capture load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      rd_q       <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
`ifdef LSU_MISALIGNED_EN
      split_q    <= 1'b0;
      strb1_q    <= '0;
      wdata1_q   <= '0;
      rdata0_q   <= '0;
`endif
    end else begin
      if (state_q == IDLE && req_valid) begin
        store_q    <= req_store;
        we_q       <= req_store;
        err_q      <= req_err;
        size_q     <= req_size;
        rd_q       <= req_rd;
        off_q      <= off;
        addr_q     <= req_addr[ADDR_WIDTH-1:LB];
        strb_q     <= req_store ? strb0 : '0;
        wdata_q    <= req_store ? data0 : '0;
        rsp_data_q <= '0;
`ifdef LSU_MISALIGNED_EN
        split_q    <= misaligned;
        strb1_q    <= req_store ? strb1 : '0;
        wdata1_q   <= req_store ? data1 : '0;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      if (state_q == WAIT0 && mem_rvalid) rdata0_q <= mem_rdata;
      if (state_q != REQ1 && state_d == REQ1) begin
        addr_q  <= addr_q + WA'(1);
        strb_q  <= strb1_q;
        wdata_q <= wdata1_q;
      end
`endif
      if ((state_q == WAIT0 || state_q == WAIT1) && state_d == RESP) rsp_data_q <= load_val;
    end
  end

  // Assemble loaded bytes from one or two beats, then sign/zero extend by size.
  always_comb begin
`ifdef LSU_MISALIGNED_EN
    pair = (state_q == WAIT1) ? {mem_rdata, rdata0_q} : {{XLEN{1'b0}}, mem_rdata};
    raw  = XLEN'(pair >> {off_q, 3'b000});
`else
    raw  = mem_rdata >> {off_q, 3'b000};
`endif
    case (size_q)
      SZ_BYTE_S: load_val = XLEN'($signed(raw[7:0]));
      SZ_HALF_S: load_val = XLEN'($signed(raw[15:0]));
      SZ_WORD:   load_val = XLEN'($signed(raw[31:0]));
      SZ_BYTE_U: load_val = XLEN'(raw[7:0]);
      SZ_HALF_U: load_val = XLEN'(raw[15:0]);
      default:   load_val = '0;
    endcase
  end

  // Outputs: decoded from registered state, memory fields zeroed when idle.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_req   = (state_q == REQ0) || (state_q == REQ1);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? addr_q  : '0;
    mem_wstrb = mem_req ? strb_q  : '0;
    mem_wdata = mem_req ? wdata_q : '0;
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_data  = rsp_valid ? rsp_data_q : '0;
    rsp_rd    = rsp_valid ? rd_q : '0;
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed self-checking bench for lsu_unit
module tb_lsu_unit;
  localparam logic [2:0] SZ_BYTE_S = 3'd0;
  localparam logic [2:0] SZ_HALF_S = 3'd1;
  localparam logic [2:0] SZ_WORD   = 3'd2;
  localparam logic [2:0] SZ_BYTE_U = 3'd4;
  localparam logic [2:0] SZ_HALF_U = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_size = '0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req, mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mem [0:127];
  logic [6:0]  b_addr [0:3];
  logic [3:0]  b_strb [0:3];
  logic [31:0] b_wdata [0:3];
  logic        b_we [0:3];
  int          nbeats, rsp_k, unstable;
  logic [31:0] r_data;
  logic        r_err;
  logic [4:0]  r_rd;

  always #5 clk = ~clk;

  lsu_unit #(.XLEN(32), .ADDR_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  // One request with a memory responder that grants after gdly cycles and returns data a cycle later.
  // rsp_k is the sample index (1 = cycle after accept) where rsp_valid was seen, -1 on timeout.
  task automatic run_access(input logic st, input logic [2:0] sz, input logic [8:0] a,
                            input logic [31:0] wd, input logic [4:0] rd, input int gdly);
    int wcnt;
    logic in_beat, pend_rv;
    logic [6:0] pend_a;
    wcnt = 0; in_beat = 1'b0; pend_rv = 1'b0; pend_a = '0;
    nbeats = 0; rsp_k = -1; unstable = 0; r_data = '0; r_err = 1'b0; r_rd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd; req_rd = rd;
    for (int k = 1; k <= 40 && rsp_k < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (rsp_valid === 1'b1) begin
        rsp_k = k; r_data = rsp_data; r_err = rsp_err; r_rd = rsp_rd;
      end
      if (pend_rv) begin
        mem_rvalid = 1'b1; mem_rdata = mem[pend_a]; pend_rv = 1'b0;
      end
      if (mem_req === 1'b1) begin
        if (!in_beat) begin
          if (nbeats < 4) begin
            b_addr[nbeats] = mem_addr; b_strb[nbeats] = mem_wstrb;
            b_wdata[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
          end
          nbeats++; in_beat = 1'b1; wcnt = 0;
        end else if (nbeats <= 4 && (mem_addr !== b_addr[nbeats-1] || mem_wstrb !== b_strb[nbeats-1] ||
                     mem_wdata !== b_wdata[nbeats-1] || mem_we !== b_we[nbeats-1])) begin
          unstable++;
        end
        if (wcnt >= gdly) begin
          mem_gnt = 1'b1; in_beat = 1'b0;
          if (mem_we === 1'b1) begin
            for (int i = 0; i < 4; i++) if (mem_wstrb[i]) mem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
          end else begin
            pend_rv = 1'b1; pend_a = mem_addr;
          end
        end else begin
          wcnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", req_ready); end
    vecs++; if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin errs++; $display("FAIL reset_mem got req=%b addr=%h strb=%b", mem_req, mem_addr, mem_wstrb); end
    vecs++; if ({rsp_valid, rsp_err, rsp_data, rsp_rd} !== '0) begin errs++; $display("FAIL reset_rsp got valid=%b data=%h", rsp_valid, rsp_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_load();
    mem[7'h04] = 32'h8000_00F0;
    run_access(1'b0, SZ_WORD, 9'h010, 32'h0, 5'd7, 0);
    vecs++; if (nbeats !== 1) begin errs++; $display("FAIL lw_beats got %0d want 1", nbeats); end
    vecs++; if (b_addr[0] !== 7'h04) begin errs++; $display("FAIL lw_addr got %h want 04", b_addr[0]); end
    vecs++; if ({b_we[0], b_strb[0]} !== 5'b0) begin errs++; $display("FAIL lw_we_strb got %b%b want 00000", b_we[0], b_strb[0]); end
    vecs++; if (rsp_k !== 3) begin errs++; $display("FAIL lw_latency got %0d want 3", rsp_k); end
    vecs++; if (r_data !== 32'h8000_00F0) begin errs++; $display("FAIL lw_data got %h want 800000f0", r_data); end
    vecs++; if ({r_err, r_rd} !== {1'b0, 5'd7}) begin errs++; $display("FAIL lw_rd_err got err=%b rd=%0d want 0/7", r_err, r_rd); end
  endtask

  task automatic test_extension();
    mem[7'h04] = 32'h8000_00F0;
    run_access(1'b0, SZ_BYTE_S, 9'h013, 32'h0, 5'd1, 0);
    vecs++; if (r_data !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_s got %h want ffffff80", r_data); end
    run_access(1'b0, SZ_BYTE_U, 9'h013, 32'h0, 5'd1, 0);
    vecs++; if (r_data !== 32'h0000_0080) begin errs++; $display("FAIL lbu got %h want 00000080", r_data); end
    run_access(1'b0, SZ_HALF_S, 9'h012, 32'h0, 5'd1, 0);
    vecs++; if (r_data !== 32'hFFFF_8000) begin errs++; $display("FAIL lh_s got %h want ffff8000", r_data); end
    run_access(1'b0, SZ_HALF_U, 9'h012, 32'h0, 5'd1, 1);
    vecs++; if (r_data !== 32'h0000_8000) begin errs++; $display("FAIL lhu got %h want 00008000", r_data); end
    vecs++; if (rsp_k !== 4) begin errs++; $display("FAIL lhu_latency got %0d want 4", rsp_k); end
  endtask

  task automatic test_store_half();
    mem[7'h01] = 32'h1122_3344;
    run_access(1'b1, SZ_HALF_S, 9'h006, 32'h0000_BEEF, 5'd3, 0);
    vecs++; if ({b_addr[0], b_strb[0], b_we[0]} !== {7'h01, 4'b1100, 1'b1}) begin errs++; $display("FAIL sh_ctrl got addr=%h strb=%b we=%b want 01/1100/1", b_addr[0], b_strb[0], b_we[0]); end
    vecs++; if (b_wdata[0] !== 32'hBEEF_0000) begin errs++; $display("FAIL sh_wdata got %h want beef0000", b_wdata[0]); end
    vecs++; if (rsp_k !== 2) begin errs++; $display("FAIL sh_latency got %0d want 2", rsp_k); end
    vecs++; if ({r_err, r_data} !== 33'h0) begin errs++; $display("FAIL sh_rsp got err=%b data=%h want 0/0", r_err, r_data); end
    vecs++; if (mem[7'h01] !== 32'hBEEF_3344) begin errs++; $display("FAIL sh_mem got %h want beef3344", mem[7'h01]); end
  endtask

  task automatic test_store_stall();
    run_access(1'b1, SZ_BYTE_U, 9'h021, 32'hFFFF_FFA5, 5'd4, 3);
    vecs++; if (unstable !== 0) begin errs++; $display("FAIL sb_stable got %0d changes want 0", unstable); end
    vecs++; if ({b_addr[0], b_strb[0]} !== {7'h08, 4'b0010}) begin errs++; $display("FAIL sb_ctrl got addr=%h strb=%b want 08/0010", b_addr[0], b_strb[0]); end
    vecs++; if (b_wdata[0][15:8] !== 8'hA5) begin errs++; $display("FAIL sb_lane got %h want a5", b_wdata[0][15:8]); end
    vecs++; if (rsp_k !== 5) begin errs++; $display("FAIL sb_latency got %0d want 5", rsp_k); end
  endtask

  task automatic test_misaligned();
    mem[7'h3F] = 32'hAABB_1234;
    mem[7'h40] = 32'h5678_CCDD;
    run_access(1'b0, SZ_WORD, 9'h0FE, 32'h0, 5'd9, 0);
`ifdef LSU_MISALIGNED_EN
    vecs++; if (nbeats !== 2) begin errs++; $display("FAIL mis_lw_beats got %0d want 2", nbeats); end
    vecs++; if ({b_addr[0], b_addr[1]} !== {7'h3F, 7'h40}) begin errs++; $display("FAIL mis_lw_addr got %h %h want 3f 40", b_addr[0], b_addr[1]); end
    vecs++; if ({r_err, r_data} !== {1'b0, 32'hCCDD_AABB}) begin errs++; $display("FAIL mis_lw_data got err=%b %h want 0 ccddaabb", r_err, r_data); end
    vecs++; if (rsp_k !== 5) begin errs++; $display("FAIL mis_lw_latency got %0d want 5", rsp_k); end
`else
    vecs++; if (nbeats !== 0) begin errs++; $display("FAIL mis_lw_beats got %0d want 0", nbeats); end
    vecs++; if ({r_err, r_data} !== {1'b1, 32'h0}) begin errs++; $display("FAIL mis_lw_err got err=%b %h want 1 0", r_err, r_data); end
    vecs++; if (rsp_k !== 1) begin errs++; $display("FAIL mis_lw_latency got %0d want 1", rsp_k); end
`endif
  endtask

  task automatic test_wrap_store();
    mem[7'h7F] = 32'h0;
    mem[7'h00] = 32'hFF00_0000;
    run_access(1'b1, SZ_WORD, 9'h1FF, 32'h1122_3344, 5'd5, 0);
`ifdef LSU_MISALIGNED_EN
    vecs++; if ({nbeats, b_addr[0], b_strb[0], b_wdata[0]} !== {32'd2, 7'h7F, 4'b1000, 32'h4400_0000}) begin errs++; $display("FAIL wrap_b0 got n=%0d addr=%h strb=%b data=%h", nbeats, b_addr[0], b_strb[0], b_wdata[0]); end
    vecs++; if ({b_addr[1], b_strb[1], b_wdata[1]} !== {7'h00, 4'b0111, 32'h0011_2233}) begin errs++; $display("FAIL wrap_b1 got addr=%h strb=%b data=%h want 00/0111/00112233", b_addr[1], b_strb[1], b_wdata[1]); end
    vecs++; if ({mem[7'h7F], mem[7'h00]} !== {32'h4400_0000, 32'hFF11_2233}) begin errs++; $display("FAIL wrap_mem got %h %h want 44000000 ff112233", mem[7'h7F], mem[7'h00]); end
    vecs++; if ({r_err, rsp_k} !== {1'b0, 32'd3}) begin errs++; $display("FAIL wrap_rsp got err=%b k=%0d want 0/3", r_err, rsp_k); end
`else
    vecs++; if ({r_err, nbeats, rsp_k} !== {1'b1, 32'd0, 32'd1}) begin errs++; $display("FAIL wrap_err got err=%b n=%0d k=%0d want 1/0/1", r_err, nbeats, rsp_k); end
`endif
  endtask

  task automatic test_undef_size();
    run_access(1'b0, 3'd7, 9'h010, 32'h0, 5'd31, 0);
    vecs++; if ({r_err, r_rd, r_data} !== {1'b1, 5'd31, 32'h0}) begin errs++; $display("FAIL undef got err=%b rd=%0d data=%h want 1/31/0", r_err, r_rd, r_data); end
    vecs++; if ({nbeats, rsp_k} !== {32'd0, 32'd1}) begin errs++; $display("FAIL undef_flow got n=%0d k=%0d want 0/1", nbeats, rsp_k); end
  endtask

  task automatic test_stray_handshake();
    logic bad;
    bad = 1'b0;
    @(negedge clk); mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_rvalid = 1'b0; mem_gnt = 1'b0;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    vecs++; if (bad) begin errs++; $display("FAIL stray_idle got rsp_valid/mem_req activity want none"); end
  endtask

  task automatic test_reset_mid();
    logic stable, saw;
    mem[7'h04] = 32'h1234_5678;
    stable = 1'b1; saw = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_WORD; req_addr = 9'h010; req_rd = 5'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); req_valid = 1'b0;
      if (mem_req !== 1'b1 || mem_addr !== 7'h04 || mem_we !== 1'b0 || mem_wstrb !== 4'b0) stable = 1'b0;
    end
    vecs++; if (!stable) begin errs++; $display("FAIL stall_stable got changing mem_* want held"); end
    mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    vecs++; if ({mem_req, req_ready} !== 2'b00) begin errs++; $display("FAIL wait0_state got req=%b ready=%b want 0/0", mem_req, req_ready); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    vecs++; if ({mem_req, mem_addr, rsp_valid, rsp_data} !== '0) begin errs++; $display("FAIL rst_mid_outs got req=%b addr=%h rsp=%b", mem_req, mem_addr, rsp_valid); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_rvalid = 1'b0;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) saw = 1'b1;
    end
    vecs++; if (saw) begin errs++; $display("FAIL rst_abandon got rsp_valid or mem_req after reset want none"); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    test_reset();
    test_aligned_load();
    test_extension();
    test_store_half();
    test_store_stall();
    test_misaligned();
    test_wrap_store();
    test_undef_size();
    test_stray_handshake();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
